// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/done handshake and abort.
module muldiv_iter #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              Start,
    input  logic [2:0]        MUL_OP,
    input  logic [DWIDTH-1:0] Op_A,
    input  logic [DWIDTH-1:0] Op_B,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic [DWIDTH-1:0] Result
);

    localparam int W  = DWIDTH;
    localparam int CW = $clog2(DWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_n;

    logic [2:0]    op;
    logic [CW-1:0] count;
    logic [W-1:0]  m;
    logic [2*W-1:0] p;
    logic          neg_q;
    logic          neg_r;

    logic load, step, fin;

    logic          a_sgn, b_sgn;
    logic          neg_a_in, neg_b_in;
    logic [W-1:0]  ma_in, mb_in;
    logic          div_zero, div_ovf, special;
    logic [W-1:0]  special_res;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] p_mul;
    logic [W:0]     div_shift, div_diff;
    logic           div_ok;
    logic [2*W-1:0] p_div;
    logic [2*W-1:0] p_step;
    logic [2*W-1:0] mul_prod;
    logic [W-1:0]   quo, rem;
    logic [W-1:0]   fin_res;

    // Operand decode for the request presented in IDLE
    always_comb begin
        a_sgn    = MUL_OP[2] ? ~MUL_OP[0] : (MUL_OP[1:0] != 2'b11);
        b_sgn    = MUL_OP[2] ? ~MUL_OP[0] : ~MUL_OP[1];
        neg_a_in = a_sgn & Op_A[W-1];
        neg_b_in = b_sgn & Op_B[W-1];
        ma_in    = neg_a_in ? -Op_A : Op_A;
        mb_in    = neg_b_in ? -Op_B : Op_B;
        div_zero = (Op_B == '0);
        div_ovf  = MUL_OP[2] & ~MUL_OP[0]
                 & (Op_A == {1'b1, {(W-1){1'b0}}})
                 & (Op_B == {W{1'b1}});
        special  = MUL_OP[2] & (div_zero | div_ovf);
        if (div_zero)
            special_res = MUL_OP[1] ? Op_A : {W{1'b1}};
        else
            special_res = MUL_OP[1] ? '0 : Op_A;
    end

    // One iteration: p holds {acc_hi, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
        p_mul     = {mul_sum, p[W-1:1]};
        div_shift = {p[2*W-1:W], p[W-1]};
        div_diff  = div_shift - {1'b0, m};
        div_ok    = ~div_diff[W];
        p_div     = {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]),
                     p[W-2:0], div_ok};
        p_step    = (state == MUL) ? p_mul : p_div;
        mul_prod  = neg_q ? -p_step : p_step;
        quo       = p_step[W-1:0];
        rem       = p_step[2*W-1:W];
        if (state == MUL)
            fin_res = (op[1:0] == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
        else if (op[1])
            fin_res = neg_r ? -rem : rem;
        else
            fin_res = neg_q ? -quo : quo;
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    load = 1'b1;
                    if (special)
                        state_n = DONE;
                    else
                        state_n = MUL_OP[2] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (Abort) begin
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == CW'(1)) begin
                        fin     = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            op     <= '0;
            count  <= '0;
            m      <= '0;
            p      <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Result <= '0;
        end else if (load) begin
            op    <= MUL_OP;
            count <= CW'(DWIDTH);
            m     <= MUL_OP[2] ? mb_in : ma_in;
            p     <= {{W{1'b0}}, (MUL_OP[2] ? ma_in : mb_in)};
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
            if (special)
                Result <= special_res;
        end else if (step) begin
            p     <= p_step;
            count <= count - CW'(1);
            if (fin)
                Result <= fin_res;
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (32-bit and 16-bit instances).
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [2:0]  mul_op;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    logic        start16;
    logic        abort16;
    logic [2:0]  mul_op16;
    logic [15:0] op_a16, op_b16;
    logic        busy16, done16;
    logic [15:0] result16;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.DWIDTH(32)) dut (
        .Clk_Core  (clk),
        .Rst_Core_N(rst_n),
        .Start     (start),
        .MUL_OP    (mul_op),
        .Op_A      (op_a),
        .Op_B      (op_b),
        .Abort     (abort),
        .Busy      (busy),
        .Done      (done),
        .Result    (result)
    );

    muldiv_iter #(.DWIDTH(16)) dut16 (
        .Clk_Core  (clk),
        .Rst_Core_N(rst_n),
        .Start     (start16),
        .MUL_OP    (mul_op16),
        .Op_A      (op_a16),
        .Op_B      (op_b16),
        .Abort     (abort16),
        .Busy      (busy16),
        .Done      (done16),
        .Result    (result16)
    );

    // Issue one op on the 32-bit unit; returns Done cycle and busy-cycle count
    task automatic run(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int dc, output int bc);
        @(negedge clk);
        start = 1'b1; mul_op = op; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        mul_op = 3'($urandom);
        op_a = $urandom;
        op_b = $urandom;
        dc = -1;
        bc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bc++;
            if (done) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags32: got %b want 00", {busy, done});
        end
        checks++;
        if (result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result32: got %h want 0", result);
        end
        checks++;
        if ({busy16, done16} !== 2'b00 || result16 !== 16'h0) begin
            fails++;
            $display("FAIL reset16: got %b/%h want 00/0",
                     {busy16, done16}, result16);
        end
    endtask

    task automatic test_arith;
        logic [2:0]  ops [14];
        logic [31:0] av  [14];
        logic [31:0] bv  [14];
        logic [31:0] ev  [14];
        int          lat [14];
        int dc, bc;
        ops = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                3'd4, 3'd6, 3'd0, 3'd5, 3'd4, 3'd6};
        av  = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                32'h7, 32'h7, 32'h80000000, 32'h80000000,
                32'h0, 32'h0};
        bv  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h2, 32'h2, 32'd7, 32'd7,
                32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h5, 32'h5};
        ev  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                32'hFFFFFFFD, 32'h1, 32'h80000000, 32'h0,
                32'h0, 32'h0};
        lat = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33};
        for (int i = 0; i < 14; i++) begin
            run(ops[i], av[i], bv[i], dc, bc);
            checks++;
            if (result !== ev[i]) begin
                fails++;
                $display("FAIL arith_result[%0d] op=%0d: got %h want %h",
                         i, ops[i], result, ev[i]);
            end
            checks++;
            if (dc !== lat[i] || bc !== lat[i]) begin
                fails++;
                $display("FAIL arith_latency[%0d]: done@%0d busy=%0d want %0d",
                         i, dc, bc, lat[i]);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops [6];
        logic [31:0] av  [6];
        logic [31:0] bv  [6];
        logic [31:0] ev  [6];
        int dc, bc;
        ops = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
        av  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        bv  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        ev  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                32'hFFFFFFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            run(ops[i], av[i], bv[i], dc, bc);
            checks++;
            if (result !== ev[i]) begin
                fails++;
                $display("FAIL special_result[%0d]: got %h want %h",
                         i, result, ev[i]);
            end
            checks++;
            if (dc !== 1 || bc !== 1) begin
                fails++;
                $display("FAIL special_latency[%0d]: done@%0d busy=%0d want 1",
                         i, dc, bc);
            end
        end
    endtask

    task automatic test_done_pulse;
        int dc, bc;
        run(3'd5, 32'd100, 32'd7, dc, bc);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00 || result !== 32'd14) begin
            fails++;
            $display("FAIL done_pulse: busy/done=%b result=%h want 00/0000000e",
                     {busy, done}, result);
        end
    endtask

    task automatic test_back_to_back;
        int dc, bc;
        run(3'd0, 32'd6, 32'd9, dc, bc);
        checks++;
        if (result !== 32'd54 || dc !== 33) begin
            fails++;
            $display("FAIL b2b_first: got %h@%0d want 00000036@33", result, dc);
        end
        run(3'd7, 32'd54, 32'd10, dc, bc);
        checks++;
        if (result !== 32'd4 || dc !== 33) begin
            fails++;
            $display("FAIL b2b_second: got %h@%0d want 00000004@33", result, dc);
        end
    endtask

    task automatic test_abort;
        int dc, bc;
        logic seen_done;
        run(3'd5, 32'd100, 32'd7, dc, bc);
        @(negedge clk);
        start = 1'b1; mul_op = 3'd4; op_a = 32'hFFFFFFF9; op_b = 32'd2;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen_done = 1'b1;
            if (c == 5) begin
                start = 1'b1; mul_op = 3'd0; op_a = 32'd3; op_b = 32'd3;
            end
            if (c == 10) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy: got %b want 0", busy);
        end
        checks++;
        if (seen_done || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got seen=%b done=%b want 0",
                     seen_done, done);
        end
        checks++;
        if (result !== 32'd14) begin
            fails++;
            $display("FAIL abort_result: got %h want 0000000e", result);
        end
        run(3'd7, 32'd100, 32'd7, dc, bc);
        checks++;
        if (result !== 32'd2 || dc !== 33) begin
            fails++;
            $display("FAIL abort_restart: got %h@%0d want 00000002@33",
                     result, dc);
        end
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mul_op = 3'd0; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_start_idle: busy got %b want 0", busy);
        end
        seen_done = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done || result !== 32'd2) begin
            fails++;
            $display("FAIL abort_start_drop: done=%b result=%h want 0/00000002",
                     seen_done, result);
        end
    endtask

    task automatic test_midop_reset;
        int dc, bc;
        logic seen_done;
        @(negedge clk);
        start = 1'b1; mul_op = 3'd0; op_a = 32'h7; op_b = 32'hFFFFFFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || result !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: busy/done=%b result=%h want 00/0",
                     {busy, done}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            fails++;
            $display("FAIL reset_no_done: got activity after reset want none");
        end
        run(3'd0, 32'h7, 32'hFFFFFFFD, dc, bc);
        checks++;
        if (result !== 32'hFFFFFFEB || dc !== 33) begin
            fails++;
            $display("FAIL post_reset_mul: got %h@%0d want ffffffeb@33",
                     result, dc);
        end
    endtask

    task automatic test_width16;
        logic [2:0]  ops [2];
        logic [15:0] av  [2];
        logic [15:0] bv  [2];
        logic [15:0] ev  [2];
        int dc;
        ops = '{3'd0, 3'd5};
        av  = '{16'h0007, 16'd100};
        bv  = '{16'hFFFD, 16'd7};
        ev  = '{16'hFFEB, 16'd14};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start16 = 1'b1; mul_op16 = ops[i]; op_a16 = av[i]; op_b16 = bv[i];
            @(negedge clk);
            start16 = 1'b0;
            op_a16 = 16'($urandom);
            op_b16 = 16'($urandom);
            dc = -1;
            for (int c = 1; c <= 24; c++) begin
                if (done16) begin
                    dc = c;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (result16 !== ev[i] || dc !== 17) begin
                fails++;
                $display("FAIL w16[%0d]: got %h@%0d want %h@17",
                         i, result16, dc, ev[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; mul_op = '0; op_a = '0; op_b = '0;
        start16 = 1'b0; abort16 = 1'b0; mul_op16 = '0;
        op_a16 = '0; op_b16 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_arith();
        test_special();
        test_done_pulse();
        test_back_to_back();
        test_abort();
        test_midop_reset();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative, multi-cycle RV32M multiply/divide unit.
- Replaces the combinational MUL_OP path of the ALU so the core can close timing at higher Clk_Core.
- Width-parametrised with a start/done handshake; the core stalls its PC and writeback while Busy is high.
- Sits beside the ALU, is fed from the ALU input muxes, and returns Result into the writeback path.

Parameters:
DWIDTH, 32, operand/result width in bits (any even value >= 8)

Ports:
Clk_Core  input  1  core clock
Rst_Core_N  input  1  reset; asynchronous, active-low
Start  input  1  request; sampled only in IDLE
MUL_OP  input  3  op, RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Op_A  input  DWIDTH  rs1 operand (multiplicand/dividend)
Op_B  input  DWIDTH  rs2 operand (multiplier/divisor)
Abort  input  1  kill in-flight op (trap/flush)
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse, Result valid
Result  output  DWIDTH  op result; held until next accepted Start

Behaviour:
- Reset: asynchronous, active-low, on Rst_Core_N. Asserting it forces state=IDLE, Busy=0, Done=0, Result=0 and clears all datapath registers immediately, including mid-operation. No Done follows reset release.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On Start=1, latch MUL_OP, Op_A, Op_B; inputs are don't-care afterwards.
  - Load step counter with DWIDTH.
  - Next state: MUL for op[2]=0; DIV for op[2]=1.
  - Special divide cases go straight to DONE.
- Special divide cases (resolved in IDLE, Done one cycle after Start):
  - Divisor = 0: DIV/DIVU quotient = all ones; REM/REMU = Op_A.
  - Signed overflow (DIV/REM with Op_A = 1<<(DWIDTH-1) and Op_B = all ones): DIV = Op_A; REM = 0.
- MUL:
  - Radix-2 shift-add on operand magnitudes, 2*DWIDTH-bit accumulator, one bit per cycle, DWIDTH cycles.
  - Signedness: MUL/MULH take both operands signed; MULHSU takes A signed, B unsigned; MULHU takes both unsigned.
  - Two's-complement negate the 2*DWIDTH product when operand signs differ.
  - MUL returns the low DWIDTH bits; the others return the high DWIDTH bits.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, DWIDTH cycles.
  - Signed ops: quotient negated when signs differ; remainder takes the sign of the dividend. Truncation toward zero.
- Counter: decrements each MUL/DIV cycle. When it reaches 0, write Result and go to DONE.
- DONE: Done=1 and Busy=1 for exactly one cycle, then unconditional return to IDLE. Start in DONE is ignored.
- Latency:
  - Start (cycle 0) to Done = DWIDTH+1 cycles; special cases = 1 cycle.
  - Back-to-back issue: next Start accepted the cycle after Done.
- Start while Busy: ignored, no effect on the in-flight op.
- Abort:
  - In MUL/DIV, Abort=1 returns the FSM to IDLE next edge. No Done; Result keeps its previous value.
  - Abort in DONE or IDLE has no effect.
  - Abort and Start together in IDLE: Abort wins, the request is dropped.
- Result changes only on entry to DONE. It is stable at all other times.

Test Plan:
- DWIDTH=32, MUL, A=7, B=0xFFFFFFFD -> Busy for cycles 1..33, Done at cycle 33, Result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2, each Done at cycle 33.
- Special cases, Done at cycle 1: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Abort at cycle 10 of a DIV -> Busy=0 at cycle 11, no Done pulse, Result unchanged. Second Start in cycle 12 completes normally. Start pulses during Busy are ignored.
- Rst_Core_N low mid-MUL -> Busy/Done/Result=0 immediately. After release, no Done until a new Start. Repeat the first scenario at DWIDTH=16: Done at cycle 17.
